// File: rtl/exec_cmd_sequencer.sv
// exec_cmd_sequencer: single-command front end for the FIFO/LIFO/buffer execute stage.
// Pre-checks full/empty, issues one opcode for one cycle, and returns data plus a status code.
module exec_cmd_sequencer #(
    parameter int SIZE         = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [SIZE-1:0]  cmd_data,
    output logic [3:0]       exe_opcode,
    output logic [SIZE-1:0]  exe_dataIn,
    input  logic [SIZE-1:0]  exe_dataOut,
    input  logic             exe_empty,
    input  logic             exe_full,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SIZE-1:0]  rsp_data,
    output logic [1:0]       rsp_status,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_FULL    = 2'b01,
        ST_EMPTY   = 2'b10,
        ST_ILLEGAL = 2'b11
    } status_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_BUF  = 4'b0100;
    localparam logic [3:0] OP_FWR  = 4'b1001;
    localparam logic [3:0] OP_FRD  = 4'b1010;
    localparam logic [3:0] OP_LWR  = 4'b1101;
    localparam logic [3:0] OP_LRD  = 4'b1110;

    localparam bit         HAS_WAIT  = (READ_LATENCY > 0);
    localparam logic [1:0] WAIT_INIT = 2'(HAS_WAIT ? READ_LATENCY - 1 : 0);

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [SIZE-1:0] data_q, data_d;
    logic [SIZE-1:0] rsp_data_q, rsp_data_d;
    status_t         rsp_status_q, rsp_status_d;
    logic [1:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

    logic       op_legal;
    logic       op_is_buf;
    logic       op_is_wr;
    logic       op_is_rd;
    logic [3:0] peek_op;

    assign op_legal  = op_q inside {OP_BUF, OP_FWR, OP_FRD, OP_LWR, OP_LRD};
    assign op_is_buf = (op_q == OP_BUF);
    assign op_is_wr  = (op_q == OP_FWR) || (op_q == OP_LWR);
    assign op_is_rd  = (op_q == OP_FRD) || (op_q == OP_LRD);
    // Peek keeps the mode bits so the stage presents that mode's flags without moving pointers.
    assign peek_op   = {op_q[3:2], 2'b00};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        wait_cnt_d   = wait_cnt_q;
        cnt_ok_d     = cnt_ok_q;
        cnt_err_d    = cnt_err_q;
        cmd_ready    = 1'b0;
        exe_opcode   = OP_NOP;
        exe_dataIn   = '0;
        rsp_valid    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!op_legal) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_ILLEGAL;
                    state_d      = S_RESP;
                end else if (op_is_buf) begin
                    state_d = S_ISSUE;
                end else begin
                    exe_opcode = peek_op;
                    if (op_is_wr && exe_full) begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_FULL;
                        state_d      = S_RESP;
                    end else if (op_is_rd && exe_empty) begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_EMPTY;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                exe_opcode   = op_q;
                exe_dataIn   = data_q;
                rsp_status_d = ST_OK;
                if (op_is_rd && HAS_WAIT) begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = S_WAIT;
                end else begin
                    rsp_data_d = op_is_wr ? '0 : exe_dataOut;
                    state_d    = S_RESP;
                end
            end

            S_WAIT: begin
                exe_opcode = peek_op;
                if (wait_cnt_q == 2'd0) begin
                    rsp_data_d   = exe_dataOut;
                    rsp_status_d = ST_OK;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end

            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    // Statistics saturate at all-ones rather than wrapping.
                    if (rsp_status_q == ST_OK) begin
                        if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
                    end else begin
                        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            data_q       <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            wait_cnt_q   <= 2'd0;
            cnt_ok_q     <= '0;
            cnt_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            wait_cnt_q   <= wait_cnt_d;
            cnt_ok_q     <= cnt_ok_d;
            cnt_err_q    <= cnt_err_d;
        end
    end

    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign cnt_ok     = cnt_ok_q;
    assign cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_exec_cmd_sequencer.sv
// Testbench for exec_cmd_sequencer: a behavioural execute stage (shared FIFO/LIFO store,
// one-cycle read latency) plus a scoreboard of expected responses.
module tb_exec_cmd_sequencer;

    localparam int SIZE   = 8;
    localparam int RL     = 1;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 10;

    localparam logic [3:0] OP_BUF = 4'b0100;
    localparam logic [3:0] OP_FWR = 4'b1001;
    localparam logic [3:0] OP_FRD = 4'b1010;
    localparam logic [3:0] OP_LWR = 4'b1101;
    localparam logic [3:0] OP_LRD = 4'b1110;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FULL    = 2'b01;
    localparam logic [1:0] ST_EMPTY   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             rsp_ready = 1'b0;
    logic [3:0]       cmd_op = 4'b0000;
    logic [SIZE-1:0]  cmd_data = '0;
    logic             cmd_ready;
    logic [3:0]       exe_opcode;
    logic [SIZE-1:0]  exe_dataIn;
    logic [SIZE-1:0]  exe_dataOut;
    logic             exe_empty;
    logic             exe_full;
    logic             rsp_valid;
    logic [SIZE-1:0]  rsp_data;
    logic [1:0]       rsp_status;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;

    exec_cmd_sequencer #(
        .SIZE(SIZE),
        .READ_LATENCY(RL),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .exe_opcode(exe_opcode),
        .exe_dataIn(exe_dataIn),
        .exe_dataOut(exe_dataOut),
        .exe_empty(exe_empty),
        .exe_full(exe_full),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .cnt_ok(cnt_ok),
        .cnt_err(cnt_err)
    );

    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] data;
        logic [1:0]      status;
        int              lat;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_ok = 0;
    int   exp_err = 0;
    time  last_drive_t = 0;

    // Execute-stage model: one store, FIFO reads from the front, LIFO reads from the back.
    logic [SIZE-1:0] mem_q[$];
    int              occ = 0;
    logic [SIZE-1:0] rd_data = '0;

    assign exe_full    = (occ == DEPTH);
    assign exe_empty   = (occ == 0);
    assign exe_dataOut = (exe_opcode == OP_BUF) ? exe_dataIn : rd_data;

    always @(posedge clk) begin
        case (exe_opcode)
            OP_FWR, OP_LWR: if (occ < DEPTH) begin mem_q.push_back(exe_dataIn); occ <= occ + 1; end
            OP_FRD: if (occ > 0) begin rd_data <= mem_q.pop_front(); occ <= occ - 1; end
            OP_LRD: if (occ > 0) begin rd_data <= mem_q.pop_back(); occ <= occ - 1; end
            default: ;
        endcase
    end

    int op_nz_cycles = 0;
    int lifo_wr_issued = 0;
    int lifo_rd_issued = 0;
    int din_leaks = 0;

    always @(negedge clk) begin
        if (exe_opcode != 4'b0000) op_nz_cycles++;
        if (exe_opcode == OP_LWR) lifo_wr_issued++;
        if (exe_opcode == OP_LRD) lifo_rd_issued++;
        if (exe_dataIn != '0 && !(exe_opcode inside {OP_BUF, OP_FWR, OP_LWR})) din_leaks++;
    end

    // Drives one command from a negedge and returns at the negedge after the response handshake.
    task automatic run_cmd(input logic [3:0] op, input logic [SIZE-1:0] data,
                           input logic [SIZE-1:0] exp_data, input logic [1:0] exp_status,
                           input int exp_lat, input int hold);
        exp_t             e;
        int               lat;
        logic [SIZE-1:0]  d0;
        logic [1:0]       s0;
        logic [CNT_W-1:0] ok0, err0;
        sb_q.push_back('{data: exp_data, status: exp_status, lat: exp_lat});
        last_drive_t = $time;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_idle op=%b: got %b expected 1", op, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'b0000;
        cmd_data  = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        vectors++;
        if (lat != e.lat) begin
            miscompares++;
            $display("FAIL latency op=%b: got %0d cycles expected %0d", op, lat, e.lat);
        end
        vectors++;
        if (rsp_data !== e.data) begin
            miscompares++;
            $display("FAIL rsp_data op=%b: got %h expected %h", op, rsp_data, e.data);
        end
        vectors++;
        if (rsp_status !== e.status) begin
            miscompares++;
            $display("FAIL rsp_status op=%b: got %b expected %b", op, rsp_status, e.status);
        end
        if (e.status == ST_OK) exp_ok++;
        else exp_err++;
        d0 = rsp_data; s0 = rsp_status; ok0 = cnt_ok; err0 = cnt_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_status !== s0 || cmd_ready !== 1'b0 ||
                cnt_ok !== ok0 || cnt_err !== err0) begin
                miscompares++;
                $display("FAIL hold_stable cycle %0d: got valid=%b data=%h st=%b rdy=%b ok=%0d err=%0d expected valid=1 data=%h st=%b rdy=0 ok=%0d err=%0d",
                         h, rsp_valid, rsp_data, rsp_status, cmd_ready, cnt_ok, cnt_err, d0, s0, ok0, err0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_counters(input string tag);
        vectors++;
        if (cnt_ok !== CNT_W'(exp_ok)) begin
            miscompares++;
            $display("FAIL %s cnt_ok: got %0d expected %0d", tag, cnt_ok, exp_ok);
        end
        vectors++;
        if (cnt_err !== CNT_W'(exp_err)) begin
            miscompares++;
            $display("FAIL %s cnt_err: got %0d expected %0d", tag, cnt_err, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({exe_opcode, exe_dataIn} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_exe: got op=%b din=%h expected 0000/00", exe_opcode, exe_dataIn);
        end
        vectors++;
        if ({rsp_valid, rsp_data, rsp_status} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_rsp: got v=%b d=%h s=%b expected 0/00/00", rsp_valid, rsp_data, rsp_status);
        end
        test_counters("reset");
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_fifo();
        run_cmd(OP_FWR, 8'h11, 8'h00, ST_OK, 3, 0);
        run_cmd(OP_FWR, 8'h22, 8'h00, ST_OK, 3, 0);
        run_cmd(OP_FRD, 8'h00, 8'h11, ST_OK, 3 + RL, 0);
        run_cmd(OP_FRD, 8'h00, 8'h22, ST_OK, 3 + RL, 0);
        test_counters("fifo");
    endtask

    task automatic test_lifo();
        int rd0;
        run_cmd(OP_LWR, 8'hA5, 8'h00, ST_OK, 3, 0);
        run_cmd(OP_LWR, 8'h5A, 8'h00, ST_OK, 3, 0);
        run_cmd(OP_LRD, 8'h00, 8'h5A, ST_OK, 3 + RL, 0);
        run_cmd(OP_LRD, 8'h00, 8'hA5, ST_OK, 3 + RL, 0);
        rd0 = lifo_rd_issued;
        run_cmd(OP_LRD, 8'h00, 8'h00, ST_EMPTY, 2, 0);
        vectors++;
        if (lifo_rd_issued != rd0) begin
            miscompares++;
            $display("FAIL empty_no_issue: got %0d 1110 cycles expected 0", lifo_rd_issued - rd0);
        end
        test_counters("lifo");
    endtask

    task automatic test_full();
        int wr0;
        for (int i = 1; i <= DEPTH; i++) run_cmd(OP_LWR, SIZE'(i), 8'h00, ST_OK, 3, 0);
        wr0 = lifo_wr_issued;
        run_cmd(OP_LWR, 8'hFF, 8'h00, ST_FULL, 2, 0);
        vectors++;
        if (lifo_wr_issued != wr0) begin
            miscompares++;
            $display("FAIL full_no_issue: got %0d 1101 cycles expected 0", lifo_wr_issued - wr0);
        end
        vectors++;
        if (occ != DEPTH) begin
            miscompares++;
            $display("FAIL full_depth: got %0d expected %0d", occ, DEPTH);
        end
        test_counters("full");
    endtask

    task automatic test_illegal_buffer();
        int nz0;
        nz0 = op_nz_cycles;
        run_cmd(4'b0111, 8'h99, 8'h00, ST_ILLEGAL, 2, 0);
        run_cmd(4'b1111, 8'h42, 8'h00, ST_ILLEGAL, 2, 0);
        vectors++;
        if (op_nz_cycles != nz0) begin
            miscompares++;
            $display("FAIL illegal_opcode_quiet: got %0d non-zero opcode cycles expected 0", op_nz_cycles - nz0);
        end
        run_cmd(OP_BUF, 8'h3C, 8'h3C, ST_OK, 3, 0);
        test_counters("illegal_buffer");
    endtask

    task automatic test_hold();
        run_cmd(OP_LRD, 8'h00, 8'h04, ST_OK, 3 + RL, 5);
        test_counters("hold");
    endtask

    task automatic test_reset_in_wait();
        cmd_valid = 1'b1;
        cmd_op    = OP_LRD;
        cmd_data  = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'b0000;
        repeat (2) @(negedge clk);
        vectors++;
        if (exe_opcode !== 4'b1100) begin
            miscompares++;
            $display("FAIL wait_peek: got %b expected 1100", exe_opcode);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({exe_opcode, rsp_valid, rsp_data, rsp_status, cmd_ready} !== {4'b0000, 1'b0, 8'h00, 2'b00, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got op=%b v=%b d=%h s=%b rdy=%b expected 0000/0/00/00/1",
                     exe_opcode, rsp_valid, rsp_data, rsp_status, cmd_ready);
        end
        sb_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        test_counters("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_stale_rsp: got rsp_valid=%b expected 0", rsp_valid);
        end
        run_cmd(OP_LRD, 8'h00, 8'h02, ST_OK, 3 + RL, 0);
        test_counters("after_reset");
    endtask

    task automatic test_back_to_back();
        time t0, t1, t2;
        run_cmd(OP_FWR, 8'h77, 8'h00, ST_OK, 3, 0);
        t0 = last_drive_t;
        run_cmd(OP_FRD, 8'h00, 8'h01, ST_OK, 3 + RL, 0);
        t1 = last_drive_t;
        run_cmd(OP_FRD, 8'h00, 8'h77, ST_OK, 3 + RL, 0);
        t2 = last_drive_t;
        vectors++;
        if (t1 - t0 != time'(4 * PERIOD)) begin
            miscompares++;
            $display("FAIL b2b_write_period: got %0t expected %0d", t1 - t0, 4 * PERIOD);
        end
        vectors++;
        if (t2 - t1 != time'((4 + RL) * PERIOD)) begin
            miscompares++;
            $display("FAIL b2b_read_period: got %0t expected %0d", t2 - t1, (4 + RL) * PERIOD);
        end
        vectors++;
        if (occ != 0) begin
            miscompares++;
            $display("FAIL final_depth: got %0d expected 0", occ);
        end
        vectors++;
        if (din_leaks != 0) begin
            miscompares++;
            $display("FAIL datain_outside_issue: got %0d cycles expected 0", din_leaks);
        end
        test_counters("back_to_back");
    endtask

    initial begin
        #(2000 * PERIOD);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fifo();
        test_lifo();
        test_full();
        test_illegal_buffer();
        test_hold();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
